// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational UART parity: par_typ 0 gives even parity, 1 gives odd parity.
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop; PRESCALE clocks per bit.
// Define UART_TX_PARITY_EN to include the parity bit in every frame.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             state, state_nxt;
  logic [PS_W-1:0]       ps_cnt, ps_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic                  par_typ_q, par_typ_nxt;
  logic                  tx_nxt;
  logic                  ps_done;
  logic                  par_lvl;

`ifdef UART_TX_PARITY_EN
  // The shift register rotates rather than shifts, so its XOR still equals the accepted word's.
  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (shift_reg),
    .par_typ(par_typ_q),
    .parity (par_lvl)
  );
`else
  logic unused_par_typ;
  assign unused_par_typ = par_typ_q;
  assign par_lvl        = UART_STOP_LVL;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    ps_nxt      = ps_cnt;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift_reg;
    par_typ_nxt = par_typ_q;
    tx_nxt      = UART_IDLE_LVL;
    ps_done     = (ps_cnt == PS_LAST);

    if (state != IDLE) begin
      ps_nxt = ps_done ? '0 : ps_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (data_valid) begin
          state_nxt   = START;
          shift_nxt   = p_data;
          par_typ_nxt = par_typ;
        end
      end
      START: begin
        if (ps_done) state_nxt = DATA;
      end
      DATA: begin
        if (ps_done) begin
          shift_nxt = {shift_reg[0], shift_reg[DATA_WIDTH-1:1]};
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (ps_done) state_nxt = STOP;
      end
      STOP: begin
        if (ps_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is decided from the upcoming state so tx_out is a clean register output.
    case (state_nxt)
      IDLE:    tx_nxt = UART_IDLE_LVL;
      START:   tx_nxt = UART_START_LVL;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_lvl;
      default: tx_nxt = UART_STOP_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ps_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_typ_q <= 1'b0;
      tx_out    <= UART_IDLE_LVL;
    end else begin
      state     <= state_nxt;
      ps_cnt    <= ps_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      par_typ_q <= par_typ_nxt;
      tx_out    <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: queue-based line model checked every cycle plus literal frame checks.
module tb_uart_tx_frame;

  localparam int DW = 8;
  localparam int PS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [15:0] LIT_A5_E = 16'h054A;
  localparam logic [15:0] LIT_A5_O = 16'h074A;
  localparam logic [15:0] LIT_01_E = 16'h0602;
  localparam logic [15:0] LIT_00_E = 16'h0400;
  localparam logic [15:0] LIT_FF_E = 16'h05FE;
  localparam int          LIT_LEN  = 88;
`else
  localparam int PB = 0;
  localparam logic [15:0] LIT_A5_E = 16'h034A;
  localparam logic [15:0] LIT_A5_O = 16'h034A;
  localparam logic [15:0] LIT_01_E = 16'h0202;
  localparam logic [15:0] LIT_00_E = 16'h0200;
  localparam logic [15:0] LIT_FF_E = 16'h03FE;
  localparam int          LIT_LEN  = 80;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          data_valid = 1'b0;
  logic          par_typ = 1'b0;
  logic          tx_out;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .DATA_WIDTH(DW),
    .PRESCALE  (PS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_typ   (par_typ),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Line model: an accepted word expands into its list of line levels, one entry per clock.
  logic exp_q[$];
  logic exp_tx   = 1'b1;
  logic exp_busy = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    logic [DW-1:0] d;
    if (!rst) begin
      exp_q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (!exp_busy && data_valid) begin
        d = p_data;
        repeat (PS) exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) repeat (PS) exp_q.push_back(d[i]);
        if (PB == 1) repeat (PS) exp_q.push_back((^d) ^ par_typ);
        repeat (PS) exp_q.push_back(1'b1);
      end
      if (exp_q.size() > 0) begin
        exp_tx   = exp_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("tx_cycle", {31'd0, tx_out}, {31'd0, exp_tx});
    check("busy_cycle", {31'd0, busy}, {31'd0, exp_busy});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [DW-1:0] d, input logic pt);
    for (int i = 0; i < 300 && busy; i++) tick();
    p_data     = d;
    par_typ    = pt;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("accept_tx0", {31'd0, tx_out}, 32'd0);
    check("accept_busy", {31'd0, busy}, 32'd1);
  endtask

  // Samples each bit at its centre from the first start-bit cycle until busy drops.
  // act_kind 1: pulse data_valid with 0xFF at act_cyc; act_kind 2: assert reset at act_cyc.
  task automatic run_frame(input int act_cyc, input int act_kind,
                           output logic [15:0] cap, output int busy_cnt);
    cap      = '0;
    busy_cnt = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      if ((c % PS) == (PS / 2) && (c / PS) < 16) cap[c/PS] = tx_out;
      busy_cnt++;
      if (c == act_cyc && act_kind == 1) begin
        p_data     = 8'hFF;
        data_valid = 1'b1;
      end else if (c == act_cyc + 1 && act_kind == 1) begin
        data_valid = 1'b0;
      end else if (c == act_cyc && act_kind == 2) begin
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, tx_out}, 32'd1);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
      end
      if (rst) tick();
    end
  endtask

  initial begin
    logic [15:0] cap;
    int          n;
    int          n2;

    repeat (3) tick();
    check("reset_tx", {31'd0, tx_out}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    #2 rst = 1'b1;
    tick();

    start_frame(8'hA5, 1'b0);
    run_frame(-10, 0, cap, n);
    check("a5_even_bits", {16'd0, cap}, {16'd0, LIT_A5_E});
    check("busy_len", n, LIT_LEN);

    start_frame(8'hA5, 1'b1);
    run_frame(-10, 0, cap, n);
    check("a5_odd_bits", {16'd0, cap}, {16'd0, LIT_A5_O});

    start_frame(8'h01, 1'b0);
    run_frame(-10, 0, cap, n);
    check("01_even_bits", {16'd0, cap}, {16'd0, LIT_01_E});

    start_frame(8'hA5, 1'b0);
    run_frame(30, 1, cap, n);
    check("midframe_ignored_bits", {16'd0, cap}, {16'd0, LIT_A5_E});
    n2 = 0;
    repeat (40) begin
      if (busy) n2++;
      tick();
    end
    check("no_second_frame", n2, 0);

    p_data     = 8'h00;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    tick();
    check("b2b_first_tx0", {31'd0, tx_out}, 32'd0);
    run_frame(-10, 0, cap, n);
    check("b2b_first_bits", {16'd0, cap}, {16'd0, LIT_00_E});
    check("b2b_gap_idle", {31'd0, busy}, 32'd0);
    check("b2b_gap_tx", {31'd0, tx_out}, 32'd1);
    p_data = 8'hFF;
    tick();
    data_valid = 1'b0;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    run_frame(-10, 0, cap, n);
    check("b2b_second_bits", {16'd0, cap}, {16'd0, LIT_FF_E});
    check("b2b_second_len", n, LIT_LEN);

    start_frame(8'hA5, 1'b0);
    run_frame(35, 2, cap, n);
    tick();
    check("rst_hold_tx", {31'd0, tx_out}, 32'd1);
    check("rst_hold_busy", {31'd0, busy}, 32'd0);
    #2 rst = 1'b1;
    tick();
    start_frame(8'h01, 1'b0);
    run_frame(-10, 0, cap, n);
    check("after_rst_bits", {16'd0, cap}, {16'd0, LIT_01_E});
    check("after_rst_len", n, LIT_LEN);

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
